// File: rtl/serial_add_ctrl_if.sv
// Handshake and operand/result bundle for serial_add_ctrl.
// Optional macro SERIAL_ADD_SUB_EN adds the 'sub' request bit.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

`ifdef SERIAL_ADD_SUB_EN
    modport master (
        output start, a, b, cin, sub,
        input  ready, busy, done, sum, cout, ovf
    );
    modport slave (
        input  start, a, b, cin, sub,
        output ready, busy, done, sum, cout, ovf
    );
`else
    modport master (
        output start, a, b, cin,
        input  ready, busy, done, sum, cout, ovf
    );
    modport slave (
        input  start, a, b, cin,
        output ready, busy, done, sum, cout, ovf
    );
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder slice reused WIDTH times, LSB first,
// behind a start/done handshake. Result registers change only when an
// operation completes. Optional macro SERIAL_ADD_SUB_EN enables a-b via
// the 'sub' request bit (invert B, force carry-in to 1).
module serial_add_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    serial_add_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             last;

    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] psum;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic             slice_s;
    logic             slice_c;
    logic             msb_cin;
    logic [WIDTH-1:0] psum_nxt;
    logic [WIDTH-1:0] b_in;
    logic             c_in;

    // Operand B and carry seed as latched on an accepted start.
`ifdef SERIAL_ADD_SUB_EN
    assign b_in = bus.sub ? ~bus.b : bus.b;
    assign c_in = bus.sub ? 1'b1 : bus.cin;
`else
    assign b_in = bus.b;
    assign c_in = bus.cin;
`endif

    // The single full-adder slice and the partial sum it completes.
    assign slice_s  = sh_a[0] ^ sh_b[0] ^ carry;
    assign slice_c  = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
    assign msb_cin  = carry;
    assign psum_nxt = {slice_s, psum[WIDTH-1:1]};

    // Status decodes straight from the state register: no input-to-output path.
    assign bus.ready = (state == IDLE) || (state == DONE);
    assign bus.busy  = (state == RUN);
    assign bus.done  = (state == DONE);
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign bus.ovf   = ovf_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is honoured in IDLE and DONE, ignored in RUN.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift registers, carry, counter and result capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_a   <= '0;
            sh_b   <= '0;
            psum   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            sh_a  <= bus.a;
            sh_b  <= b_in;
            carry <= c_in;
            cnt   <= '0;
        end else if (state == RUN) begin
            sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
            sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
            psum  <= psum_nxt;
            carry <= slice_c;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum_q  <= psum_nxt;
                cout_q <= slice_c;
                ovf_q  <= msb_cin ^ slice_c;
            end
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=32.
// Optional macro SERIAL_ADD_SUB_EN adds the subtraction vectors.
module tb_serial_add_ctrl;
    localparam int WIDTH = 32;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait edge by edge for done, bounded; n = edges waited.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.done && n < 100);
    endtask

    // Present a request at the negedge so it is accepted on the next edge.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic sub);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub   = sub;
`else
        if (sub) bus.cin = cin;
`endif
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic sub, input logic [WIDTH-1:0] e_sum,
                          input logic e_cout, input logic e_ovf);
        int n;
        issue(a, b, cin, sub);
        chk({tag, ".busy"}, 64'(bus.busy), 64'd1);
        chk({tag, ".ready"}, 64'(bus.ready), 64'd0);
        wait_done(n);
        chk({tag, ".latency"}, 64'(n), 64'(WIDTH));
        chk({tag, ".sum"}, 64'(bus.sum), 64'(e_sum));
        chk({tag, ".cout"}, 64'(bus.cout), 64'(e_cout));
        chk({tag, ".ovf"}, 64'(bus.ovf), 64'(e_ovf));
        @(posedge clk);
        #1;
        chk({tag, ".done_1cyc"}, 64'(bus.done), 64'd0);
        chk({tag, ".sum_hold"}, 64'(bus.sum), 64'(e_sum));
    endtask

    initial begin
        int  n;
        bit  bad;
        n_assert  = 0;
        n_fail    = 0;
        clk       = 1'b0;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub   = 1'b0;
`endif
        #2 reset = 1'b1;
        #2;
        chk("rst.ready", 64'(bus.ready), 64'd1);
        chk("rst.busy",  64'(bus.busy),  64'd0);
        chk("rst.done",  64'(bus.done),  64'd0);
        chk("rst.sum",   64'(bus.sum),   64'd0);
        chk("rst.cout",  64'(bus.cout),  64'd0);
        chk("rst.ovf",   64'(bus.ovf),   64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        run_op("add1_2",    32'h00000001, 32'h00000002, 1'b0, 1'b0, 32'h00000003, 1'b0, 1'b0);
        run_op("addFF_1",   32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
        run_op("addFF_FF",  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
        run_op("ovf_pos",   32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
        run_op("ovf_neg",   32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1);
        run_op("mixed",     32'h12345678, 32'h0FEDCBA9, 1'b1, 1'b0, 32'h22222222, 1'b0, 1'b0);

        // 3+4 with an ignored start mid-RUN, then back-to-back 10+20 from DONE.
        issue(32'd3, 32'd4, 1'b0, 1'b0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        bus.start = 1'b1;
        bus.a     = 32'd100;
        bus.b     = 32'd100;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("ign.busy", 64'(bus.busy), 64'd1);
        wait_done(n);
        chk("ign.latency", 64'(n + 6), 64'(WIDTH));
        chk("ign.sum", 64'(bus.sum), 64'd7);
        bus.start = 1'b1;
        bus.a     = 32'd10;
        bus.b     = 32'd20;
        bus.cin   = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("b2b.busy", 64'(bus.busy), 64'd1);
        chk("b2b.done", 64'(bus.done), 64'd0);
        bad = 1'b0;
        n   = 0;
        do begin
            if (bus.sum !== 32'd7) bad = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end while (!bus.done && n < 100);
        chk("b2b.sum_hold", 64'(bad), 64'd0);
        chk("b2b.latency", 64'(n), 64'(WIDTH));
        chk("b2b.sum", 64'(bus.sum), 64'd30);

        // Reset in RUN cycle 10: result cleared at once, no done afterwards.
        issue(32'h12345678, 32'h00000001, 1'b0, 1'b0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        chk("mid.busy", 64'(bus.busy), 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("mid.ready", 64'(bus.ready), 64'd1);
        chk("mid.busy0", 64'(bus.busy),  64'd0);
        chk("mid.done",  64'(bus.done),  64'd0);
        chk("mid.sum",   64'(bus.sum),   64'd0);
        chk("mid.cout",  64'(bus.cout),  64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        bad = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad = 1'b1;
        end
        chk("mid.no_done", 64'(bad), 64'd0);
        run_op("after_rst", 32'd5, 32'd6, 1'b0, 1'b0, 32'd11, 1'b0, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        run_op("sub5_7",    32'd5,        32'd7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_op("sub7_5",    32'd7,        32'd5, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0);
        run_op("sub_ovf",   32'h80000000, 32'd1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
        run_op("sub0_add",  32'd9,        32'd4, 1'b1, 1'b0, 32'd14,       1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Sequencer that computes a WIDTH-bit addition by driving a single 1-bit full-adder slice (sum/carry of a+b+cin) once per clock, LSB first. It trades the WIDTH-slice ripple adder for one slice plus shift registers, a bit counter and a start/done handshake. It sits beside the ripple adder as the area-minimal option for slow control-path arithmetic.

## Interface
- WIDTH, 32, operand/result width in bits; legal range 2..64
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when ready=1
- a  input  WIDTH  operand A, latched on accepted start
- b  input  WIDTH  operand B, latched on accepted start
- cin  input  1  carry-in, latched on accepted start
- ready  output  1  block can accept start this cycle
- busy  output  1  serial addition in progress
- done  output  1  one-cycle pulse: result registers updated
- sum  output  WIDTH  result, held until next completion
- cout  output  1  carry-out of bit WIDTH-1
- ovf  output  1  signed overflow (carry into MSB XOR cout)

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- ready = (state==IDLE or state==DONE); busy = (state==RUN); done = (state==DONE).
- Accepted start (start=1 and ready=1): latch a into shift reg A, b into shift reg B, carry reg <= cin, bit counter <= 0, state <= RUN.
- RUN, each edge: slice inputs = A[0], B[0], carry reg; shift A and B right by 1; shift slice sum into MSB of partial-sum reg; carry reg <= slice carry; counter += 1.
- At the RUN edge where counter == WIDTH-1: also record carry-in of that bit as msb_cin; copy completed partial sum to sum, slice carry to cout, (msb_cin XOR slice carry) to ovf; state <= DONE.
- DONE: if start=1, accept it (same as IDLE, back-to-back); else state <= IDLE.
- start while busy: ignored, no effect on operands or result.
- sum/cout/ovf change only on the edge entering DONE; stable otherwise, including through a following RUN.
- Arithmetic: modulo 2^WIDTH; {cout,sum} == a + b + cin exactly.

## Timing
- Start accepted at edge 0; RUN occupies edges 1..WIDTH; sum/cout/ovf/done valid in the cycle after edge WIDTH (latency WIDTH cycles, WIDTH=32 -> 32).
- done high exactly one cycle per operation.
- Throughput: one op per WIDTH+1 cycles; back-to-back start in DONE gives one op per WIDTH+1 cycles with no IDLE gap.
- Reset values (asynchronous, immediate): state IDLE, ready=1, busy=0, done=0, sum=0, cout=0, ovf=0, counter=0, shift/carry regs=0.
- Reset mid-RUN: operation abandoned, no done pulse, previous result cleared to 0.
- No combinational path from inputs to outputs.

## Configuration
- Macro SERIAL_ADD_SUB_EN.
- Defined: extra port sub (input, 1 bit) latched on accepted start; sub=1 latches ~b into shift reg B and seeds carry reg with 1 (cin ignored), giving a-b; cout=1 means no borrow; ovf is signed subtraction overflow. sub=0 behaves as plain add.
- Undefined: port sub absent; add only, behaviour exactly as above.

## Test plan
- WIDTH=32, a=0x00000001, b=0x00000002, cin=0 -> sum=0x00000003, cout=0, ovf=0; done exactly 32 cycles after start edge, single-cycle.
- a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, ovf=0; a=0xFFFFFFFF, b=0xFFFFFFFF, cin=1 -> sum=0xFFFFFFFF, cout=1.
- a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1; a=0x80000000, b=0x80000000 -> sum=0, cout=1, ovf=1.
- start with a=3,b=4; pulse start with a=100,b=100 during RUN -> ignored, sum=7; start asserted in DONE cycle with a=10,b=20 -> accepted, busy next cycle, sum=30 after 32 more cycles, sum holds 7 throughout RUN.
- reset asserted at RUN cycle 10 -> outputs 0 and ready=1 immediately, no done; subsequent a=5,b=6 -> sum=11.
- SERIAL_ADD_SUB_EN defined: a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0; a=7, b=5, sub=1 -> sum=2, cout=1; a=0x80000000, b=1, sub=1 -> ovf=1.
